fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the `rom` instruction memory. It owns the program counter, drives the ROM's `address`/`enable` inputs, captures the returned word into a one-entry output register, and presents it to decode with a valid/ready handshake. It also supports branch redirect and halt-on-sentinel.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational ROM.
//
// Owns the program counter, strobes the ROM with the current PC whenever the
// one-entry output register can take a new word, and presents captured words
// to decode over a valid/ready handshake. A branch redirect flushes the output
// register and reloads the PC. Capturing the HALT_INSN sentinel stops fetching
// until the next redirect.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rom_address, rom_enable         ROM request (address is 0 when not enabled)
//   rom_data                        same-cycle ROM read data
//   instr_out, pc_out, instr_valid  captured word, its address, valid flag
//   instr_ready                     decode accepts the presented word
//   redirect_valid, redirect_pc     branch redirect request and target
//   halted                          high while stopped on the sentinel
//   fetch_count                     words captured since reset (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_address,
  output logic        rom_enable,
  input  logic [31:0] rom_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_next, pc_out_next;
  logic        valid_next;
  logic [15:0] count_next;
  logic        slot_free;
  logic        fetch;

  // The output register can take a word when empty or being drained now.
  assign slot_free   = !instr_valid || instr_ready;
  // A redirect suppresses the fetch: the old PC is stale that cycle.
  assign fetch       = (state_reg == RUN) && slot_free && !redirect_valid;
  assign rom_enable  = fetch;
  assign rom_address = fetch ? pc_reg : 32'h0;
  assign halted      = (state_reg == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_PC;
      instr_out   <= 32'h0;
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_out   <= instr_next;
      pc_out      <= pc_out_next;
      instr_valid <= valid_next;
      fetch_count <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_out;
    pc_out_next = pc_out;
    valid_next  = instr_valid;
    count_next  = fetch_count;

    if (redirect_valid) begin
      // Flush wins even if decode accepts in the same cycle; the accept
      // itself still completes on the decode side.
      pc_next    = {redirect_pc[31:2], 2'b00};
      valid_next = 1'b0;
      state_next = RUN;
    end else begin
      unique case (state_reg)
        BOOT: begin
          state_next = RUN;
        end
        RUN: begin
          if (fetch) begin
            instr_next  = rom_data;
            pc_out_next = pc_reg;
            valid_next  = 1'b1;
            pc_next     = pc_reg + 32'd4;
            count_next  = fetch_count + 16'd1;
            if (rom_data == HALT_INSN) begin
              state_next = HALTED;
            end
          end else if (slot_free && instr_ready) begin
            valid_next = 1'b0;
          end
        end
        HALTED: begin
          // Sentinel stays presented until decode takes it.
          if (instr_ready) begin
            valid_next = 1'b0;
          end
        end
        default: begin
          state_next = BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus for fetch_unit, checked by a
// scoreboard. The stimulus process predicts, from a stream-level reference
// model, what the DUT must show each cycle and which (pc, word) pairs decode
// must receive; a separate monitor pops and compares on every falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_address, rom_data, instr_out, pc_out, redirect_pc;
  logic        rom_enable, instr_valid, instr_ready, redirect_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] w_address, w_data, w_instr, w_pc_out;
  logic        w_enable, w_valid, w_halted;
  logic [15:0] w_count;

  logic [31:0] halt_addr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rom_address(rom_address), .rom_enable(rom_enable), .rom_data(rom_data),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .fetch_count(fetch_count)
  );

  // Second instance exercising PC wraparound from a high reset address.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .rom_address(w_address), .rom_enable(w_enable), .rom_data(w_data),
    .instr_out(w_instr), .pc_out(w_pc_out), .instr_valid(w_valid),
    .instr_ready(1'b1), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .halted(w_halted), .fetch_count(w_count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == halt_addr) ? 32'hFFFF_FFFF : (32'hA000_0000 + a);
  endfunction

  always_comb rom_data = rom_word(rom_address);
  always_comb w_data   = rom_word(w_address);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic        hlt;
    logic [15:0] cnt;
    logic        vld;
  } cyc_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } xfer_t;

  cyc_t  cyc_q[$];
  xfer_t xfer_q[$];

  // Reference model: the next address to fetch, whether decode currently
  // holds an unconsumed word, and the fetcher's mode.
  logic [31:0] m_next_addr;
  logic        m_holding;
  logic        m_booting, m_stopped;
  logic [15:0] m_words;

  task automatic model_reset();
    m_next_addr = 32'h0;
    m_holding   = 1'b0;
    m_booting   = 1'b1;
    m_stopped   = 1'b0;
    m_words     = 16'h0;
  endtask

  // Called at posedge+1: apply inputs for this cycle, predict, advance a cycle.
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc);
    cyc_t  c;
    logic  wants;
    logic [31:0] w;
    instr_ready    = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    wants = !m_booting && !m_stopped && !rv && (!m_holding || r);
    c.en   = wants;
    c.addr = wants ? m_next_addr : 32'h0;
    c.hlt  = m_stopped;
    c.cnt  = m_words;
    c.vld  = m_holding;
    cyc_q.push_back(c);
    if (rv) begin
      // A word not taken this cycle is discarded by the flush.
      if (m_holding && !r) void'(xfer_q.pop_back());
      m_holding   = 1'b0;
      m_next_addr = rpc & 32'hFFFF_FFFC;
      m_booting   = 1'b0;
      m_stopped   = 1'b0;
    end else if (wants) begin
      w = rom_word(m_next_addr);
      xfer_q.push_back('{pc: m_next_addr, word: w});
      m_holding   = 1'b1;
      m_next_addr = m_next_addr + 32'd4;
      m_words     = m_words + 16'd1;
      if (w == 32'hFFFF_FFFF) m_stopped = 1'b1;
    end else begin
      if (r) m_holding = 1'b0;
      m_booting = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},    {31'h0, rom_enable}, 32'h0);
    chk({tag, "_addr"},  rom_address, 32'h0);
    chk({tag, "_instr"}, instr_out, 32'h0);
    chk({tag, "_pcout"}, pc_out, 32'h0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_halt"},  {31'h0, halted}, 32'h0);
    chk({tag, "_cnt"},   {16'h0, fetch_count}, 32'h0);
  endtask

  // Monitor: per-cycle outputs and accepted transfers.
  always @(negedge clk) begin
    cyc_t  c;
    xfer_t x;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("rom_enable",  {31'h0, rom_enable}, {31'h0, c.en});
      chk("rom_address", rom_address, c.addr);
      chk("halted",      {31'h0, halted}, {31'h0, c.hlt});
      chk("fetch_count", {16'h0, fetch_count}, {16'h0, c.cnt});
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, c.vld});
    end
    if (rst_n && instr_valid && instr_ready) begin
      if (xfer_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL xfer_unexpected: got pc %h insn %h expected none", pc_out, instr_out);
      end else begin
        x = xfer_q.pop_front();
        chk("xfer_pc",   pc_out, x.pc);
        chk("xfer_insn", instr_out, x.word);
        $display("xfer pc=%h insn=%h", pc_out, instr_out);
      end
    end
  end

  // Wraparound instance: first three fetch addresses after the first reset.
  initial begin : wrap_check
    logic [31:0] seen[3];
    int          got;
    got = 0;
    @(posedge rst_n);
    for (int i = 0; i < 10 && got < 3; i++) begin
      @(negedge clk);
      if (w_enable) begin
        seen[got] = w_address;
        got++;
      end
    end
    chk("wrap_count", got, 3);
    if (got == 3) begin
      chk("wrap_addr0", seen[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", seen[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", seen[2], 32'h0000_0000);
    end
  end

  initial begin : stim
    logic        r, rv;
    logic [31:0] rpc;
    halt_addr      = 32'h0000_1000;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rst_n          = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Boot and sequential streaming: fetches 0..16.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    chk("boot_count", {16'h0, fetch_count}, 32'd5);
    chk("boot_pcout", pc_out, 32'h10);

    // Backpressure then resume.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    chk("bp_hold_insn", instr_out, 32'hA000_0010);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

    // Redirect with an unaligned target while a word is held.
    step(1'b0, 1'b0, 32'h0);
    halt_addr = 32'h0000_004C;
    step(1'b0, 1'b1, 32'h0000_0043);
    chk("redir_flush", {31'h0, instr_valid}, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    chk("halt_flag", {31'h0, halted}, 32'h1);

    // Leave halt by redirecting to 0; halts again on the word at 12.
    halt_addr = 32'h0000_000C;
    step(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) step(($urandom_range(0, 3) != 0), 1'b0, 32'h0);

    // Randomized traffic with occasional redirects and moving sentinel.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if (rv) halt_addr = $urandom_range(4, 40) * 4;
      step(r, rv, rpc);
    end

    // Asynchronous reset between edges, then boot again.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    cyc_q.delete();
    xfer_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    halt_addr = 32'h0000_1000;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    chk("reboot_count", {16'h0, fetch_count}, 32'd5);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
